// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: streams WORDS 16-bit words, LSW first, through one external ripple_16 adder.
// Optional subtract mode is compiled in with `define MP_ADD_SEQ_SUB_EN (adds the sub port).
module mp_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [16*WORDS-1:0]    a_in,
    input  logic [16*WORDS-1:0]    b_in,
    input  logic                   cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [16*WORDS-1:0]    sum_out,
    output logic                   cout_out,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    output logic                   add_cin,
    input  logic [15:0]            add_sum,
    input  logic                   add_cout
);

    localparam int unsigned WW = 16;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       state_q;
    state_t                       state_d;

    logic [WORDS-1:0][WW-1:0]     a_q;
    logic [WORDS-1:0][WW-1:0]     b_q;
    logic [WORDS-1:0][WW-1:0]     res_q;
    logic [WORDS-1:0][WW-1:0]     sum_q;
    logic [WORDS-1:0][WW-1:0]     sum_d;
    logic                         carry_q;
    logic                         carry_init;
    logic                         cout_q;
    logic [IW-1:0]                idx_q;
    logic                         last_c;
    logic                         sub_q;

    assign last_c   = (idx_q == IW'(WORDS - 1));
    assign sum_out  = sum_q;
    assign cout_out = cout_q;

`ifdef MP_ADD_SEQ_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced high.
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign carry_init = cin;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; adder is driven only from registers and only in RUN
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_q[idx_q];
                add_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
                add_cin = carry_q;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Final word comes straight from the adder; lower words from res_q
    always_comb begin
        sum_d          = res_q;
        sum_d[WORDS-1] = add_sum;
    end

    // Operand, carry, index and result datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= carry_init;
                        idx_q   <= '0;
`ifdef MP_ADD_SEQ_SUB_EN
                        sub_q   <= sub;
`else
                        sub_q   <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    res_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (last_c) begin
                        idx_q  <= '0;
                        sum_q  <= sum_d;
                        cout_q <= add_cout;
                    end else begin
                        idx_q  <= IW'(idx_q + IW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Randomised and directed bench for mp_add_seq (WORDS=4) with a ripple_16 behavioural adder.
module tb_mp_add_seq;

    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic           cin = 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
    logic           sub = 1'b0;
`endif
    logic           busy;
    logic           done;
    logic [W-1:0]   sum_out;
    logic           cout_out;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic           add_cin;
    logic [15:0]    add_sum;
    logic           add_cout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]   prev_sum  = '0;
    logic           prev_cout = 1'b0;

    always #5 clk = ~clk;

    mp_add_seq #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
`ifdef MP_ADD_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // ripple_16 stand-in
    assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int i = 0; i < int'(WORDS); i++) r[i*16 +: 16] = 16'($urandom);
        return r;
    endfunction

    // Whole-width reference: A+B+cin, or A-B as A+~B+1
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic s, input int inj_at, output logic cin_all1);
        logic [W:0] exp;
        int         cyc;
        int         busy_n;
        logic       seen;
        exp = model(a, b, c, s);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; cin = c;
`ifdef MP_ADD_SEQ_SUB_EN
        sub = s;
`endif
        @(negedge clk);
        start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
`ifdef MP_ADD_SEQ_SUB_EN
        sub = ~s;
`endif
        check({tag, "_hold"}, 128'({cout_out, sum_out}), 128'({prev_cout, prev_sum}));
        cyc = 1; busy_n = 0; cin_all1 = 1'b1; seen = 1'b0;
        while (cyc <= 20 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) begin
                    busy_n++;
                    if (!add_cin) cin_all1 = 1'b0;
                end
                if (cyc == inj_at) begin
                    start = 1'b1; a_in = rnd_word(); b_in = rnd_word(); cin = ~c;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 128'(seen ? cyc : 0), 128'(WORDS + 1));
        check({tag, "_busy_cycles"}, 128'(busy_n), 128'(WORDS));
        check({tag, "_sum"}, 128'(sum_out), 128'(exp[W-1:0]));
        check({tag, "_cout"}, 128'(cout_out), 128'(exp[W]));
        check({tag, "_busy_in_done"}, 128'(busy), 128'(0));
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(done), 128'(0));
        prev_sum  = exp[W-1:0];
        prev_cout = exp[W];
    endtask

    initial begin
        logic         cin1;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           extra_done;

        #12;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_sum", 128'({cout_out, sum_out}), 128'(0));
        check("rst_adder", 128'({add_a, add_b, add_cin}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("basic", W'(64'h001F), W'(64'h000C), 1'b0, 1'b0, 0, cin1);
        check("basic_sum_const", 128'(sum_out), 128'(64'h2B));
        run_op("ripple", {W{1'b1}}, '0, 1'b1, 1'b0, 0, cin1);
        check("ripple_cin_all1", 128'(cin1), 128'(1));
        check("ripple_sum_const", 128'({cout_out, sum_out}), 128'({1'b1, 64'h0}));
        run_op("msw_ovf", W'(64'h8000000000000000), W'(64'h8000000000000000), 1'b0, 1'b0, 0, cin1);
        run_op("mixed", W'(64'hC61F00000000FFFF), W'(64'h018C000000000001), 1'b1, 1'b0, 0, cin1);
        check("mixed_const", 128'({cout_out, sum_out}), 128'({1'b0, 64'hC7AB000000010001}));

        // Second start two cycles into RUN must be ignored
        run_op("inj", W'(64'h1234_5678_9ABC_DEF0), W'(64'h0FED_CBA9_8765_4321), 1'b0, 1'b0, 2, cin1);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("inj_no_second_op", 128'(extra_done), 128'(0));

        // Reset during RUN word 2
        @(negedge clk);
        start = 1'b1; a_in = rnd_word(); b_in = rnd_word(); cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_done", 128'(done), 128'(0));
        check("midrst_sum", 128'({cout_out, sum_out}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0; prev_cout = 1'b0;
        run_op("post_rst", W'(64'h00FF_FFFF_0000_FFFF), W'(64'h0001_0001_FFFF_0001), 1'b0, 1'b0, 0, cin1);

        for (int t = 0; t < 25; t++) begin
            ra = rnd_word(); rb = rnd_word(); rc = 1'($urandom);
            if (t % 5 == 0) ra = {W{1'b1}};
`ifdef MP_ADD_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rand%0d", t), ra, rb, rc, rs, 0, cin1);
        end

`ifdef MP_ADD_SEQ_SUB_EN
        run_op("sub_neg", W'(64'h5), W'(64'h7), 1'b0, 1'b1, 0, cin1);
        check("sub_neg_const", 128'({cout_out, sum_out}), 128'({1'b0, 64'hFFFFFFFFFFFFFFFE}));
        run_op("sub_pos", W'(64'h7), W'(64'h5), 1'b0, 1'b1, 0, cin1);
        check("sub_pos_const", 128'({cout_out, sum_out}), 128'({1'b1, 64'h2}));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
